// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction/data memory bridge.
package rv_pkg;

    localparam int RV_DPWIDTH = 32;
    localparam int RV_AWIDTH  = 32;

    // Read data returned when an access is abandoned by the watchdog
    localparam logic [RV_DPWIDTH-1:0] RV_ERR_DATA = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_D_WAIT  = 2'd2
    } rv_mem_state_t;

endpackage

// File: rtl/rv_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear.
module rv_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge clk) begin
        if (!rst)
            o_cnt <= '0;
        else if (i_inc && (o_cnt != '1))
            o_cnt <= o_cnt + W'(1);
    end

endmodule

// File: rtl/rv_mem_bridge.sv
// Arbitrates instruction fetch and data ports onto one single-port memory; data wins ties.
// Optional watchdog with sticky mem_err when RV_MEM_TIMEOUT_EN is defined.
module rv_mem_bridge
    import rv_pkg::*;
#(
    parameter int DPWIDTH   = RV_DPWIDTH,
    parameter int AWIDTH    = RV_AWIDTH,
    parameter int TO_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [AWIDTH-1:0]  if_addr,
    output logic [DPWIDTH-1:0] if_rdata,
    output logic               if_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [AWIDTH-1:0]  d_addr,
    input  logic [DPWIDTH-1:0] d_wdata,
    output logic [DPWIDTH-1:0] d_rdata,
    output logic               d_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [AWIDTH-1:0]  mem_addr,
    output logic [DPWIDTH-1:0] mem_wdata,
    input  logic [DPWIDTH-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic [15:0]        stall_cnt
`ifdef RV_MEM_TIMEOUT_EN
    ,
    output logic               mem_err
`endif
);

    rv_mem_state_t r_state;
    logic          w_stall;

`ifdef RV_MEM_TIMEOUT_EN
    localparam int WDW = $clog2(TO_CYCLES + 1);
    localparam logic [DPWIDTH-1:0] ERR_DATA = DPWIDTH'(RV_ERR_DATA);
    logic [WDW-1:0] r_wd;
    logic           r_err;
    assign mem_err = r_err;
`endif

    assign busy    = (r_state != ST_IDLE);
    assign w_stall = mem_req && !mem_ready;

    rv_sat_cnt #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
`ifdef RV_MEM_TIMEOUT_EN
            r_wd      <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef RV_MEM_TIMEOUT_EN
                    r_wd <= '0;
`endif
                    // mem_ready seen here belongs to no access and is dropped
                    if (d_req) begin
                        r_state   <= ST_D_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (if_req) begin
                        r_state  <= ST_IF_WAIT;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                default: begin
                    if (mem_ready) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        if (r_state == ST_IF_WAIT) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we)
                                d_rdata <= mem_rdata;
                        end
                    end
`ifdef RV_MEM_TIMEOUT_EN
                    else if (r_wd == WDW'(TO_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        r_err   <= 1'b1;
                        if (r_state == ST_IF_WAIT) begin
                            if_done  <= 1'b1;
                            if_rdata <= ERR_DATA;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we)
                                d_rdata <= ERR_DATA;
                        end
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Self-checking bench for rv_mem_bridge: directed scenarios plus randomized accesses
// checked against a word-addressed memory model and running expected-state variables.
module tb_rv_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, mem_req, mem_we, busy;
    logic [15:0] stall_cnt;
`ifdef RV_MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    rv_mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .stall_cnt (stall_cnt)
`ifdef RV_MEM_TIMEOUT_EN
        ,
        .mem_err   (mem_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_if, exp_d;
    int          exp_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    task automatic chk_done(input bit exp_ifd, input bit exp_dd);
        chk("if_done", if_done, exp_ifd);
        chk("d_done", d_done, exp_dd);
        chk("if_rdata", if_rdata, exp_if);
        chk("d_rdata", d_rdata, exp_d);
        chk("stall_cnt", stall_cnt, exp_stall);
    endtask

    // One complete access: request, dly wait cycles, completion, then idle cycle.
    task automatic access(input bit isd, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly);
        logic [31:0] rd;
        if (isd) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin if_req = 1; if_addr = addr; end
        tick;
        d_req = 0; if_req = 0;
        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
        chk("busy_wait", busy, 1);
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, isd & we);
        chk("mem_addr", mem_addr, addr);
        if (isd && we) chk("mem_wdata", mem_wdata, wd);
        for (int i = 0; i < dly; i++) begin
            if (dly < 100) begin
                if_req = 1'($urandom); d_req = 1'($urandom);
                d_addr = $urandom; if_addr = $urandom; d_wdata = $urandom;
            end
            tick;
            if (dly < 100 || i == dly - 1) begin
                chk("hold_req", mem_req, 1);
                chk("hold_addr", mem_addr, addr);
                chk("hold_we", mem_we, isd & we);
                if (isd && we) chk("hold_wdata", mem_wdata, wd);
                chk("no_done", if_done | d_done, 0);
            end
        end
        if_req = 0; d_req = 0;
        rd = (isd && we) ? $urandom : model_rd(addr);
        if (isd && we) mem_model[addr] = wd;
        mem_ready = 1; mem_rdata = rd;
        tick;
        mem_ready = 0; mem_rdata = $urandom;
        exp_stall = (exp_stall + dly > 16'hFFFF) ? 16'hFFFF : exp_stall + dly;
        if (isd) begin if (!we) exp_d = rd; end
        else exp_if = rd;
        chk_done(!isd, isd);
        chk("busy_done", busy, 0);
        chk("mem_req_drop", mem_req, 0);
        tick;
        chk_done(0, 0);
    endtask

    task automatic chk_all_zero;
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stall", stall_cnt, 0);
    endtask

    initial begin
        rst = 0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        exp_if = 0; exp_d = 0; exp_stall = 0;
        tick; tick;
        chk_all_zero();
        rst = 1;
        tick;

        // fetch, zero-wait memory: done two edges after request
        mem_model[32'h100] = 32'h0050_0093;
        access(0, 0, 32'h100, 0, 0);
        chk("fetch_word", if_rdata, 32'h0050_0093);

        // store with 3 stall cycles
        access(1, 1, 32'h40, 32'hDEAD_BEEF, 3);
        chk("store_stall", stall_cnt, 3);

        // simultaneous requests: data first, pending fetch follows
        mem_model[32'h2000] = 32'h1234_5678;
        mem_model[32'h300]  = 32'h0000_0013;
        d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h300;
        tick;
        d_req = 0;
        chk("arb_addr", mem_addr, 32'h2000);
        chk("arb_we", mem_we, 0);
        mem_ready = 1; mem_rdata = mem_model[32'h2000];
        tick;
        mem_ready = 0;
        exp_d = 32'h1234_5678;
        chk_done(0, 1);
        tick;
        if_req = 0;
        chk_done(0, 0);
        chk("arb_busy", busy, 1);
        chk("arb_if_addr", mem_addr, 32'h300);
        mem_ready = 1; mem_rdata = mem_model[32'h300];
        tick;
        mem_ready = 0;
        exp_if = 32'h0000_0013;
        chk_done(1, 0);
        tick;
        chk_done(0, 0);

        // stray mem_ready while idle
        mem_ready = 1; mem_rdata = $urandom;
        tick;
        mem_ready = 0;
        chk_done(0, 0);
        chk("idle_busy", busy, 0);

        // randomized traffic over a small address window
        for (int n = 0; n < 40; n++) begin
            logic        isd, we;
            logic [31:0] a;
            isd = 1'($urandom);
            we  = isd & 1'($urandom);
            a   = {26'd0, 4'($urandom), 2'b00};
            access(isd, we, a, $urandom, $urandom_range(0, 5));
        end

        // reset in the middle of a data wait
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick;
        d_req = 0;
        tick; tick;
        rst = 0;
        tick;
        rst = 1;
        exp_if = 0; exp_d = 0; exp_stall = 0;
        chk_all_zero();
        mem_ready = 1;
        tick;
        mem_ready = 0;
        chk("post_rst_done", if_done | d_done, 0);
        chk("post_rst_busy", busy, 0);
        tick;
        chk("post_rst_done2", if_done | d_done, 0);

        // long stall saturates the counter
        access(1, 0, 32'h80, 0, 70000);
        chk("stall_sat", stall_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
